// File: rtl/wptr_level_handler.sv
// wptr_level_handler: write-side pointer controller of the asynchronous FIFO.
// Keeps the binary and Gray write pointers and derives the RAM write address
// and strobe. The synchronised Gray read pointer is decoded here to produce a
// registered fill level, full / almost-full flags and a sticky overflow flag.
// The optional read-pointer integrity checker is enabled by defining the macro
// WPTR_RPTR_CHECK_EN, which adds the sticky rptr_err output.

module wptr_level_handler #(
   parameter int unsigned PTR_WIDTH    = 3,
   parameter int unsigned AFULL_THRESH = 2**PTR_WIDTH - 2
) (
   input  logic                 clk_w,
   input  logic                 arst_n,
   input  logic                 w_en,
   input  logic                 clr_ovf,
   input  logic [PTR_WIDTH:0]   g_rptr_sync,
   output logic [PTR_WIDTH-1:0] w_addr,
   output logic                 w_fire,
   output logic [PTR_WIDTH:0]   b_wptr,
   output logic [PTR_WIDTH:0]   g_wptr,
   output logic [PTR_WIDTH:0]   w_level,
   output logic                 full,
   output logic                 almost_full,
   output logic                 overflow
`ifdef WPTR_RPTR_CHECK_EN
   ,
   output logic                 rptr_err
`endif
);

   // Pointer-width constants; the extra MSB distinguishes full from empty.
   localparam logic [PTR_WIDTH:0] DEPTH_V = {1'b1, {PTR_WIDTH{1'b0}}};
   localparam logic [PTR_WIDTH:0] AFULL_V = AFULL_THRESH[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

   logic [PTR_WIDTH:0] b_wptr_q, b_wptr_d;
   logic [PTR_WIDTH:0] g_wptr_q, g_wptr_d;
   logic [PTR_WIDTH:0] w_level_q, w_level_d;
   logic               full_q, full_d;
   logic               afull_q, afull_d;
   logic               ovf_q, ovf_d;
   logic [PTR_WIDTH:0] b_rptr;

   // Write acceptance: a write is taken only when the FIFO is not full.
   always_comb begin
      w_fire = w_en & ~full_q;
   end

   // Decode the synchronised Gray read pointer by an XOR prefix from the MSB.
   always_comb begin
      b_rptr            = '0;
      b_rptr[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH];
      for (int i = int'(PTR_WIDTH) - 1; i >= 0; i--) begin
         b_rptr[i] = b_rptr[i+1] ^ g_rptr_sync[i];
      end
   end

   // Next pointers, level and flags; level arithmetic wraps modulo 2**(PTR_WIDTH+1).
   always_comb begin
      b_wptr_d  = b_wptr_q + {{PTR_WIDTH{1'b0}}, w_fire};
      g_wptr_d  = b_wptr_d ^ (b_wptr_d >> 1);
      w_level_d = b_wptr_d - b_rptr;
      // Exact compare: an out-of-range level from a corrupt read pointer never
      // reads as full.
      full_d    = (w_level_d == DEPTH_V);
      afull_d   = (w_level_d >= AFULL_V);
   end

   // Sticky overflow: a rejected write sets it, and setting beats clearing.
   always_comb begin
      ovf_d = ovf_q;
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end
      if (w_en && full_q) begin
         ovf_d = 1'b1;
      end
   end

   // Write-domain state register; everything clears asynchronously on reset.
   always_ff @(posedge clk_w or negedge arst_n) begin
      if (!arst_n) begin
         b_wptr_q  <= '0;
         g_wptr_q  <= '0;
         w_level_q <= '0;
         full_q    <= 1'b0;
         afull_q   <= (AFULL_V == '0);
         ovf_q     <= 1'b0;
      end else begin
         b_wptr_q  <= b_wptr_d;
         g_wptr_q  <= g_wptr_d;
         w_level_q <= w_level_d;
         full_q    <= full_d;
         afull_q   <= afull_d;
         ovf_q     <= ovf_d;
      end
   end

`ifdef WPTR_RPTR_CHECK_EN
   logic [PTR_WIDTH:0] g_rptr_prev_q;
   logic [PTR_WIDTH:0] g_rptr_diff;
   logic               rptr_err_q, rptr_err_d;
   logic               multi_bit;

   // A legal synchronised Gray pointer moves by at most one bit per cycle and
   // can never imply a level beyond the FIFO depth.
   always_comb begin
      g_rptr_diff = g_rptr_sync ^ g_rptr_prev_q;
      multi_bit   = |(g_rptr_diff & (g_rptr_diff - PTR_ONE));
      rptr_err_d  = rptr_err_q | multi_bit | (w_level_d > DEPTH_V);
   end

   // Checker history and sticky error; only reset clears the error.
   always_ff @(posedge clk_w or negedge arst_n) begin
      if (!arst_n) begin
         g_rptr_prev_q <= '0;
         rptr_err_q    <= 1'b0;
      end else begin
         g_rptr_prev_q <= g_rptr_sync;
         rptr_err_q    <= rptr_err_d;
      end
   end

   assign rptr_err = rptr_err_q;
`else
   // Keeps the unused constant referenced in the default build.
   logic unused_ptr_one;
   assign unused_ptr_one = ^PTR_ONE;
`endif

   assign w_addr      = b_wptr_q[PTR_WIDTH-1:0];
   assign b_wptr      = b_wptr_q;
   assign g_wptr      = g_wptr_q;
   assign w_level     = w_level_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_level_handler.sv
// Scoreboard bench for wptr_level_handler (PTR_WIDTH=3, AFULL_THRESH=6).
// Each vector drives one cycle of inputs and queues the outputs expected while
// those inputs are applied; a monitor pops and compares on the falling edge.

module tb_wptr_level_handler;

   logic       clk_w;
   logic       arst_n;
   logic       w_en;
   logic       clr_ovf;
   logic [3:0] g_rptr_sync;
   logic [2:0] w_addr;
   logic       w_fire;
   logic [3:0] b_wptr;
   logic [3:0] g_wptr;
   logic [3:0] w_level;
   logic       full;
   logic       almost_full;
   logic       overflow;
`ifdef WPTR_RPTR_CHECK_EN
   logic       rptr_err;
`endif

   typedef struct {
      logic       fire;
      logic [3:0] b;
      logic [3:0] g;
      logic [3:0] lvl;
      logic       f;
      logic       af;
      logic       ov;
      logic       er;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   wptr_level_handler #(
      .PTR_WIDTH    (3),
      .AFULL_THRESH (6)
   ) dut (
      .clk_w       (clk_w),
      .arst_n      (arst_n),
      .w_en        (w_en),
      .clr_ovf     (clr_ovf),
      .g_rptr_sync (g_rptr_sync),
      .w_addr      (w_addr),
      .w_fire      (w_fire),
      .b_wptr      (b_wptr),
      .g_wptr      (g_wptr),
      .w_level     (w_level),
      .full        (full),
      .almost_full (almost_full),
      .overflow    (overflow)
`ifdef WPTR_RPTR_CHECK_EN
      ,
      .rptr_err    (rptr_err)
`endif
   );

   initial begin
      clk_w = 1'b0;
      forever #5 clk_w = ~clk_w;
   end

   function automatic logic [3:0] gray4(input int v);
      logic [3:0] b;
      b = v[3:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s vec=%0d act=%0d exp=%0d t=%0t", name, n_vec, act, exp, $time);
      end
   endtask

   // One cycle of stimulus plus the outputs expected during that cycle.
   task automatic vec(input logic rst, input logic we, input logic clr, input logic [3:0] g,
                      input logic fire, input int b, input int lvl, input logic f,
                      input logic af, input logic ov, input logic er);
      exp_t e;
      @(posedge clk_w);
      #1;
      arst_n      = rst;
      w_en        = we;
      clr_ovf     = clr;
      g_rptr_sync = g;
      e.fire = fire;
      e.b    = 4'(b);
      e.g    = gray4(b);
      e.lvl  = 4'(lvl);
      e.f    = f;
      e.af   = af;
      e.ov   = ov;
      e.er   = er;
      sb.push_back(e);
   endtask

   // Monitor: compare on the falling edge, away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_w);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            chk("w_fire", int'(w_fire), int'(e.fire));
            chk("b_wptr", int'(b_wptr), int'(e.b));
            chk("g_wptr", int'(g_wptr), int'(e.g));
            chk("w_addr", int'(w_addr), int'(e.b[2:0]));
            chk("w_level", int'(w_level), int'(e.lvl));
            chk("full", int'(full), int'(e.f));
            chk("almost_full", int'(almost_full), int'(e.af));
            chk("overflow", int'(overflow), int'(e.ov));
`ifdef WPTR_RPTR_CHECK_EN
            chk("rptr_err", int'(rptr_err), int'(e.er));
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      arst_n      = 1'b0;
      w_en        = 1'b0;
      clr_ovf     = 1'b0;
      g_rptr_sync = 4'b0000;
      repeat (2) @(posedge clk_w);

      //  rst we  clr g          fire b   lvl full af  ovf err
      // Reset released, idle.
      vec(1, 0, 0, 4'b0000,   0,  0,  0,  0,  0,  0,  0);
      // Eight writes with the read pointer at zero.
      for (int i = 0; i < 8; i++) begin
         vec(1, 1, 0, 4'b0000, 1, i, i, 0, (i >= 6), 0, 0);
      end
      // Ninth write while full is rejected and sets overflow.
      vec(1, 1, 0, 4'b0000,   0,  8,  8,  1,  1,  0,  0);
      vec(1, 0, 1, 4'b0000,   0,  8,  8,  1,  1,  1,  0);
      // Set and clear in the same cycle: set wins.
      vec(1, 1, 1, 4'b0000,   0,  8,  8,  1,  1,  0,  0);
      vec(1, 0, 1, 4'b0000,   0,  8,  8,  1,  1,  1,  0);
      // Read pointer advances by one: full drops, level 7.
      vec(1, 0, 0, 4'b0001,   0,  8,  8,  1,  1,  0,  0);
      // Write and read step in the same cycle: level unchanged.
      vec(1, 1, 0, 4'b0011,   1,  8,  7,  0,  1,  0,  0);
      // Twenty writes interleaved with read advances; write pointer wraps.
      for (int j = 0; j < 20; j++) begin
         vec(1, 1, 0, gray4(3 + j), 1, (9 + j) % 16, 7, 0, 1, 0, 0);
      end
      vec(1, 0, 0, gray4(6),  0, 13,  7,  0,  1,  0,  0);
      // Read side drains to empty.
      vec(1, 0, 0, gray4(13), 0, 13,  7,  0,  1,  0,  0);
      // Two-bit jump of the read pointer; level goes out of range, full stays low.
      vec(1, 0, 0, 4'b1000,   0, 13,  0,  0,  0,  0,  0);
      vec(1, 0, 0, 4'b1000,   0, 13, 14,  0,  1,  0,  1);
      vec(1, 1, 0, 4'b1000,   1, 13, 14,  0,  1,  0,  1);
      vec(1, 1, 0, 4'b1000,   1, 14, 15,  0,  1,  0,  1);
      // Reset asserted mid-burst clears everything at once.
      vec(0, 0, 0, 4'b0000,   0,  0,  0,  0,  0,  0,  0);
      vec(1, 1, 0, 4'b0000,   1,  0,  0,  0,  0,  0,  0);
      vec(1, 0, 0, 4'b0000,   0,  1,  1,  0,  0,  0,  0);

      @(posedge clk_w);
      @(negedge clk_w);
      #1;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain pending=%0d exp=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/wptr_level_handler.md
Name: wptr_level_handler

Overview:
Parametrised write-side pointer controller for the asynchronous FIFO; successor to the fixed 3-bit write pointer handler.
- Generates binary and Gray write pointers and the RAM write address.
- Converts the synchronised Gray read pointer to binary and derives a registered fill level, full and almost-full flags.
- Provides a sticky overflow flag.
- Sits in the write clock domain, between the producer interface, the FIFO RAM and the 2-FF synchroniser that carries g_wptr to the read side.

Parameters:
PTR_WIDTH, 3, address bits; FIFO depth DEPTH = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits; legal range 2..10.
AFULL_THRESH, 2**PTR_WIDTH-2, level at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
clk_w  input  1  write-domain clock; all state updates on rising edge.
arst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk_w (external synchroniser).
w_en  input  1  producer write request.
clr_ovf  input  1  synchronous clear of the overflow flag.
g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer, already synchronised into clk_w.
w_addr  output  PTR_WIDTH  RAM write address = b_wptr[PTR_WIDTH-1:0].
w_fire  output  1  combinational w_en & ~full; RAM write strobe.
b_wptr  output  PTR_WIDTH+1  binary write pointer.
g_wptr  output  PTR_WIDTH+1  Gray write pointer, registered; drives the CDC synchroniser.
w_level  output  PTR_WIDTH+1  registered fill level, 0..DEPTH.
full  output  1  registered full flag.
almost_full  output  1  registered, w_level_next >= AFULL_THRESH.
overflow  output  1  sticky: write attempted while full.

Behaviour:
- Reset (arst_n=0, asynchronous): b_wptr=0, g_wptr=0, w_level=0, full=0, almost_full=0 (or 1 if AFULL_THRESH==0, which is illegal anyway), overflow=0; plus the optional-feature state.
- Reset mid-operation clears all state in the same instant; no write is accepted while arst_n=0.
- Acceptance: w_fire = w_en & ~full. Increment width is exactly PTR_WIDTH+1 bits; no hardcoded widths.
- b_wptr_next = b_wptr + w_fire; g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1). Both registered, so g_wptr always equals gray(b_wptr) with no combinational path to the output.
- b_rptr = Gray-to-binary of g_rptr_sync (XOR prefix from MSB), combinational.
- w_level_next = b_wptr_next - b_rptr, modulo 2**(PTR_WIDTH+1).
- Registered flags, one cycle after the write that causes them:
  - full <= (w_level_next == DEPTH), equivalent to the MSB-2-inverted Gray compare.
  - almost_full <= (w_level_next >= AFULL_THRESH).
  - w_level <= w_level_next.
- Wrap-around: pointers roll from 2**(PTR_WIDTH+1)-1 to 0. w_addr wraps every DEPTH writes. Level arithmetic stays correct across the wrap.
- Full: w_en while full is ignored; pointers hold and overflow <= 1.
- Freeing space: full deasserts the cycle after g_rptr_sync advances. The read-side sync latency makes the flags pessimistic, never optimistic.
- overflow: set on w_en & full; cleared by clr_ovf. If both occur in the same cycle, set wins.
- A single-bit change of g_rptr_sync and a write in the same cycle are both reflected in w_level_next; level stays unchanged.
- w_level_next > DEPTH can only come from an illegal read pointer. full is computed with ==, so it does not assert on that value; see the optional checker.

Optional Feature:
Macro WPTR_RPTR_CHECK_EN.
- Defined: adds output rptr_err (1 bit, reset 0) and a register holding the previous g_rptr_sync. rptr_err is set sticky, cleared only by reset, when either:
  - the new g_rptr_sync differs from the previous value in more than one bit (Hamming distance >1), or
  - w_level_next > DEPTH.
- Not defined: no rptr_err port and no extra registers; behaviour otherwise identical.

Test Plan:
1. Reset then idle, PTR_WIDTH=3, AFULL_THRESH=6 -> all outputs 0; w_addr=0.
2. 8 consecutive writes, g_rptr_sync=0:
   - w_level 1..8; almost_full=1 one cycle after the 6th write; full=1 one cycle after the 8th write.
   - b_wptr=4'b1000, g_wptr=4'b1100.
3. Ninth write while full -> b_wptr stays 8, w_fire=0, overflow=1. Then clr_ovf=1 with w_en=0 -> overflow=0 next cycle.
4. From full, step g_rptr_sync 0000->0001 -> full=0, w_level=7 next cycle. Write+read step in the same cycle -> w_level unchanged.
5. Wrap: 20 writes interleaved with read-pointer advances -> b_wptr wraps 15->0, w_addr follows low bits, level stays correct, g_wptr changes exactly one bit per write.
6. With WPTR_RPTR_CHECK_EN: g_rptr_sync jumps 0000->0011 -> rptr_err=1 and stays 1 until arst_n asserts. arst_n pulse mid-burst -> all outputs 0 immediately.
